// File: rtl/tl_instruction_fetch_segmentado_pkg.sv
// Shared constants for the pipelined instruction-fetch stage.
package tl_instruction_fetch_segmentado_pkg;

   localparam int DEFAULT_LEN     = 32;
   localparam int DEFAULT_NB_ADDR = 8;

   // Encoding placed in IF/ID when an instruction is squashed.
   localparam logic [DEFAULT_LEN-1:0] NOP_CODE = '0;

   // Default halt encoding: all ones.
   localparam logic [DEFAULT_LEN-1:0] DEFAULT_HALT_CODE = '1;

   // Byte distance between consecutive instruction words.
   localparam int PC_INC = 4;

endpackage

// File: rtl/tl_instruction_fetch_segmentado_instruction_memory.sv
// Instruction memory: combinational read, synchronous write port used for
// program loading. The write port is unaffected by reset.
module tl_instruction_fetch_segmentado_instruction_memory #(
  parameter int len          = 32,
  parameter int NB_ADDR      = 8,
  parameter     INIT_FILE_IM = ""
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [len-1:0]     wr_data,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [len-1:0]     rd_data
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [len-1:0] mem [0:DEPTH-1];

  // Power-up contents: zero-filled.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  // Program-load write; a read in the same cycle still returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tl_instruction_fetch_segmentado.sv
// Pipelined instruction fetch: PC register, instruction memory lookup and the
// IF/ID pipeline register, with redirect, stall, flush and sticky halt.
//
// Control semantics: i_PCSrc redirects the PC (word-aligned) and squashes the
// word being fetched; i_stall freezes PC and IF/ID; i_flush squashes the word
// being fetched without touching the PC. Fetching HALT_CODE with no
// stall/flush/redirect latches o_halt and freezes PC and IF/ID until reset.
module tl_instruction_fetch_segmentado
   import tl_instruction_fetch_segmentado_pkg::*;
#(
   parameter int             len          = DEFAULT_LEN,
   parameter int             NB_ADDR      = DEFAULT_NB_ADDR,
   parameter                 INIT_FILE_IM = "",
   parameter logic [len-1:0] HALT_CODE    = {len{1'b1}}
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [len-1:0]     i_branch_dir,
   input  logic               i_PCSrc,
   input  logic               i_stall,
   input  logic               i_flush,
   input  logic               i_wr_en,
   input  logic [NB_ADDR-1:0] i_wr_addr,
   input  logic [len-1:0]     i_wr_data,
   output logic [len-1:0]     o_instruccion,
   output logic [len-1:0]     o_adder,
   output logic [len-1:0]     o_pc,
   output logic               o_valid,
   output logic               o_halt
);

   localparam logic [len-1:0] ALIGN_MASK = ~len'(3);
   localparam logic [len-1:0] NOP_WORD   = len'(NOP_CODE);

   logic [len-1:0] pc_q;
   logic [len-1:0] instr_q;
   logic [len-1:0] adder_q;
   logic           valid_q;
   logic           halt_q;

   logic [len-1:0] mem_word;
   logic [len-1:0] pc_plus4;
   logic           halt_fetch;

   tl_instruction_fetch_segmentado_instruction_memory #(
      .len          (len),
      .NB_ADDR      (NB_ADDR),
      .INIT_FILE_IM (INIT_FILE_IM)
   ) instruction_memory (
      .clk     (i_clk),
      .wr_en   (i_wr_en),
      .wr_addr (i_wr_addr),
      .wr_data (i_wr_data),
      .rd_addr (pc_q[NB_ADDR+1:2]),
      .rd_data (mem_word)
   );

   assign pc_plus4   = pc_q + len'(PC_INC);
   assign halt_fetch = (mem_word == HALT_CODE) && !halt_q && !i_PCSrc
                       && !i_stall && !i_flush;

   // PC and sticky halt: reset > halt > redirect > stall > halt capture > PC+4.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         pc_q   <= '0;
         halt_q <= 1'b0;
      end else if (halt_q) begin
         pc_q <= pc_q;
      end else if (i_PCSrc) begin
         pc_q <= i_branch_dir & ALIGN_MASK;
      end else if (i_stall) begin
         pc_q <= pc_q;
      end else if (halt_fetch) begin
         halt_q <= 1'b1;
      end else begin
         pc_q <= pc_plus4;
      end
   end

   // IF/ID register: reset > squash (flush/redirect) > hold (stall/halt) > capture.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         instr_q <= NOP_WORD;
         adder_q <= '0;
         valid_q <= 1'b0;
      end else if (i_flush || i_PCSrc) begin
         instr_q <= NOP_WORD;
         adder_q <= '0;
         valid_q <= 1'b0;
      end else if (i_stall || halt_q) begin
         instr_q <= instr_q;
         adder_q <= adder_q;
         valid_q <= valid_q;
      end else begin
         instr_q <= mem_word;
         adder_q <= pc_plus4;
         valid_q <= 1'b1;
      end
   end

   assign o_instruccion = instr_q;
   assign o_adder       = adder_q;
   assign o_pc          = pc_q;
   assign o_valid       = valid_q;
   assign o_halt        = halt_q;

endmodule

// File: tb/tb_tl_instruction_fetch_segmentado.sv
// Bench for the fetch stage: directed per-cycle vectors push the expected
// post-edge outputs into a queue; a monitor pops and compares after each edge.
// A second instance with NB_ADDR=4 covers address wrap-around.
module tb_tl_instruction_fetch_segmentado;

   localparam int W  = 32;
   localparam int EW = 2 + 3 * W;  // {halt, valid, pc, adder, instr}

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp4_q[$];

   // ---------------- main instance (NB_ADDR = 8) ----------------
   logic          rst_n = 1'b0, pcsrc = 1'b0, stall = 1'b0, flush = 1'b0, wen = 1'b0;
   logic [W-1:0]  bdir = '0, wdata = '0;
   logic [7:0]    waddr = '0;
   logic [W-1:0]  instr, adder, pc;
   logic          valid, halt;

   tl_instruction_fetch_segmentado #(.len(W), .NB_ADDR(8)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_branch_dir(bdir), .i_PCSrc(pcsrc),
      .i_stall(stall), .i_flush(flush), .i_wr_en(wen), .i_wr_addr(waddr),
      .i_wr_data(wdata), .o_instruccion(instr), .o_adder(adder), .o_pc(pc),
      .o_valid(valid), .o_halt(halt)
   );

   // ---------------- wrap instance (NB_ADDR = 4) ----------------
   logic          rst4_n = 1'b0, pcsrc4 = 1'b0, stall4 = 1'b0, flush4 = 1'b0, wen4 = 1'b0;
   logic [W-1:0]  bdir4 = '0, wdata4 = '0;
   logic [3:0]    waddr4 = '0;
   logic [W-1:0]  instr4, adder4, pc4;
   logic          valid4, halt4;

   tl_instruction_fetch_segmentado #(.len(W), .NB_ADDR(4)) dut4 (
      .i_clk(clk), .i_rst(rst4_n), .i_branch_dir(bdir4), .i_PCSrc(pcsrc4),
      .i_stall(stall4), .i_flush(flush4), .i_wr_en(wen4), .i_wr_addr(waddr4),
      .i_wr_data(wdata4), .o_instruccion(instr4), .o_adder(adder4), .o_pc(pc4),
      .o_valid(valid4), .o_halt(halt4)
   );

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic r, input logic ps, input logic st, input logic fl,
                      input logic [W-1:0] bd, input logic we, input logic [7:0] wa,
                      input logic [W-1:0] wd, input logic [W-1:0] e_instr,
                      input logic [W-1:0] e_adder, input logic [W-1:0] e_pc,
                      input logic e_valid, input logic e_halt);
      @(negedge clk);
      rst_n = r; pcsrc = ps; stall = st; flush = fl; bdir = bd;
      wen = we; waddr = wa; wdata = wd;
      exp_q.push_back({e_halt, e_valid, e_pc, e_adder, e_instr});
   endtask

   task automatic cyc4(input logic r, input logic ps, input logic [W-1:0] bd,
                       input logic we, input logic [3:0] wa, input logic [W-1:0] wd,
                       input logic [W-1:0] e_instr, input logic [W-1:0] e_adder,
                       input logic [W-1:0] e_pc, input logic e_valid);
      @(negedge clk);
      rst4_n = r; pcsrc4 = ps; stall4 = 1'b0; flush4 = 1'b0; bdir4 = bd;
      wen4 = we; waddr4 = wa; wdata4 = wd;
      exp4_q.push_back({1'b0, e_valid, e_pc, e_adder, e_instr});
   endtask

   // ---------------- monitors / scoreboard ----------------
   int step_main = 0;
   int step_wrap = 0;

   always begin
      logic [EW-1:0] e, got;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {halt, valid, pc, adder, instr};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL ifid_main step %0d: got halt=%b valid=%b pc=%h adder=%h instr=%h, exp halt=%b valid=%b pc=%h adder=%h instr=%h",
                     step_main, got[EW-1], got[EW-2], got[3*W-1:2*W], got[2*W-1:W], got[W-1:0],
                     e[EW-1], e[EW-2], e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
         end
         step_main++;
      end
   end

   always begin
      logic [EW-1:0] e, got;
      @(posedge clk);
      #1;
      if (exp4_q.size() > 0) begin
         e   = exp4_q.pop_front();
         got = {halt4, valid4, pc4, adder4, instr4};
         checks++;
         if (got !== e) begin
            failures++;
            $display("FAIL ifid_wrap step %0d: got halt=%b valid=%b pc=%h adder=%h instr=%h, exp halt=%b valid=%b pc=%h adder=%h instr=%h",
                     step_wrap, got[EW-1], got[EW-2], got[3*W-1:2*W], got[2*W-1:W], got[W-1:0],
                     e[EW-1], e[EW-2], e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
         end
         step_wrap++;
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0]   load_addr [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd16};
   logic [W-1:0] load_data [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'hA0};
   logic [3:0]   load4_addr [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd15};
   logic [W-1:0] load4_data [5] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'hF0};

   localparam logic [W-1:0] HALT = 32'hFFFF_FFFF;

   initial begin
      // Reset held low while the program is loaded; outputs stay at reset values.
      for (int i = 0; i < 6; i++)
         cyc(0, 0, 0, 0, 0, 1, load_addr[i], load_data[i], 0, 0, 0, 0, 0);

      // Sequential fetch after release.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h11, 32'h04, 32'h04, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h22, 32'h08, 32'h08, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h33, 32'h0C, 32'h0C, 1, 0);

      // Redirect to 0x40: bubble, then mem[16].
      cyc(1, 1, 0, 0, 32'h40, 0, 0, 0, 0, 0, 32'h40, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'hA0, 32'h44, 32'h44, 1, 0);

      // Redirect under stall to unaligned 0x07 -> PC 0x04.
      cyc(1, 1, 1, 0, 32'h07, 0, 0, 0, 0, 0, 32'h04, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h22, 32'h08, 32'h08, 1, 0);

      // Stall three cycles at PC 0x8, then resume with mem[2].
      for (int i = 0; i < 3; i++)
         cyc(1, 0, 1, 0, 0, 0, 0, 0, 32'h22, 32'h08, 32'h08, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h33, 32'h0C, 32'h0C, 1, 0);

      // Stall with flush: PC holds, bubble. Flush alone: PC advances, bubble.
      cyc(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0C, 0, 0);
      cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h55, 32'h14, 32'h14, 1, 0);

      // Write halt into word 5 while fetching it: old (zero) data captured.
      cyc(1, 0, 0, 0, 0, 1, 8'd5, HALT, 0, 32'h18, 32'h18, 1, 0);
      cyc(1, 1, 0, 0, 32'h14, 0, 0, 0, 0, 0, 32'h14, 0, 0);
      // Redirect on the edge that would capture the halt word wins.
      cyc(1, 1, 0, 0, 32'h16, 0, 0, 0, 0, 0, 32'h14, 0, 0);
      // Halt captured.
      cyc(1, 0, 0, 0, 0, 0, 0, 0, HALT, 32'h18, 32'h14, 1, 1);
      // Frozen for 20 cycles; a program write still lands during halt.
      for (int i = 0; i < 20; i++)
         cyc(1, 0, (i % 2 == 0), 0, 0, (i == 5), 8'd8, 32'h88, HALT, 32'h18, 32'h14, 1, 1);

      // Reset while stall and redirect are both high.
      cyc(0, 1, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h11, 32'h04, 32'h04, 1, 0);
      // Word written during halt is visible.
      cyc(1, 1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 32'h20, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h88, 32'h24, 32'h24, 1, 0);
      @(negedge clk);
      rst_n = 1'b0;

      // Wrap-around instance.
      for (int i = 0; i < 5; i++)
         cyc4(0, 0, 0, 1, load4_addr[i], load4_data[i], 0, 0, 0, 0);
      cyc4(1, 1, 32'h3C, 0, 0, 0, 0, 0, 32'h3C, 0);
      cyc4(1, 0, 0, 0, 0, 0, 32'hF0, 32'h40, 32'h40, 1);
      cyc4(1, 0, 0, 0, 0, 0, 32'h10, 32'h44, 32'h44, 1);
      cyc4(1, 0, 0, 1, 4'd3, 32'hABCD, 32'h11, 32'h48, 32'h48, 1);
      cyc4(1, 0, 0, 0, 0, 0, 32'h12, 32'h4C, 32'h4C, 1);
      cyc4(1, 0, 0, 0, 0, 0, 32'hABCD, 32'h50, 32'h50, 1);
      cyc4(1, 1, 32'h0C, 0, 0, 0, 0, 0, 32'h0C, 0);
      cyc4(1, 0, 0, 0, 0, 0, 32'hABCD, 32'h10, 32'h10, 1);

      // Drain, bounded.
      for (int i = 0; i < 4 && (exp_q.size() > 0 || exp4_q.size() > 0); i++) begin
         @(posedge clk);
         #2;
      end
      if (exp_q.size() > 0 || exp4_q.size() > 0) begin
         failures++;
         $display("FAIL drain: pending main=%0d wrap=%0d, required 0", exp_q.size(), exp4_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
